alu_share_arbiter: RTL

Round-robin scheduler that shares one 5-bit logic/arithmetic unit among `NUM_REQ` requesters. Each requester hands over an opcode and two operands using a valid/ready handshake. The block sequences the shared unit through a small state machine and returns the result with a one-cycle, one-hot response pulse. It sits between the requester-side logic and the shared AND/OR/ADD datapath, so that the datapath is never instantiated once per requester.

---
 rtl/alu_share_arbiter_pkg.sv | 21 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 35 +++
 rtl/alu_share_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the round-robin ALU sharing block: opcodes and FSM states.
package alu_share_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_MIX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // MIX needs the extra EXEC2 pass through the shared adder.
  function automatic logic needs_exec2(input logic [1:0] op);
    return (op == OP_MIX);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx
);

  logic w_found;
  int   w_idx;

  // First asserted request after last_grant wins; nothing is granted while disabled.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(last_grant) + k;
      w_idx = (w_idx >= NUM_REQ) ? (w_idx - NUM_REQ) : w_idx;
      if (enable && !w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = IDXW'(w_idx);
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one AND/OR/ADD datapath among NUM_REQ requesters with round-robin
// arbitration and a one-hot, one-cycle response pulse.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDXW-1:0]    r_last_grant;
  logic [IDXW-1:0]    r_grant_idx;
  logic [IDXW-1:0]    w_grant_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_arb_en;
  logic               w_accept;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_and;
  logic [WIDTH-1:0]   r_or;
  logic [WIDTH-1:0]   r_res;
  logic [1:0]         w_sel_op;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [NUM_REQ-1:0] w_rsp_onehot;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_busy;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign w_arb_en = (r_state == ST_IDLE) && rst_n;
  assign w_accept = |w_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

  // Select the winning requester's opcode and operands.
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDXW'(i)) begin
        w_sel_op = req_op[2*i +: 2];
        w_sel_a  = req_a[WIDTH*i +: WIDTH];
        w_sel_b  = req_b[WIDTH*i +: WIDTH];
      end else begin
        w_sel_op = w_sel_op;
      end
    end
  end

  // Response target decode.
  always_comb begin
    w_rsp_onehot              = '0;
    w_rsp_onehot[r_grant_idx] = 1'b1;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_EXEC1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC1: begin
        if (needs_exec2(r_op)) begin
          w_next_state = ST_EXEC2;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      ST_EXEC2: w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request capture and grant bookkeeping on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IDXW'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_op         <= w_sel_op;
      r_a          <= w_sel_a;
      r_b          <= w_sel_b;
      r_grant_idx  <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end
  end

  // Shared datapath: EXEC1 produces AND/OR/ADD, EXEC2 folds the MIX term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_and <= '0;
      r_or  <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        ST_EXEC1: begin
          r_and <= r_a & r_b;
          r_or  <= r_a | r_b;
          case (r_op)
            OP_AND:  r_res <= r_a & r_b;
            OP_OR:   r_res <= r_a | r_b;
            OP_ADD:  r_res <= r_a + r_b;
            default: r_res <= r_res;
          endcase
        end
        ST_EXEC2: r_res <= r_and & (r_and + r_or);
        default:  r_res <= r_res;
      endcase
    end
  end

  // Registered outputs; the pulse is produced out of RESP and lands in the next IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      if (r_state == ST_RESP) begin
        r_rsp_valid <= w_rsp_onehot;
        r_rsp_data  <= r_res;
      end else begin
        r_rsp_valid <= '0;
        r_rsp_data  <= '0;
      end
    end
  end

endmodule
